pipe_stall_ctrl: RTL and testbench
==================================

# pipe_stall_ctrl

Central stall and sequencing controller for the five-stage pipeline. It produces the 6-bit stall bus consumed by every pipeline register and by the forwarding registers. It resolves load-use hazards and memory wait requests. It also sequences the multi-cycle divider: a start pulse, a wait for completion, result capture, and release of EX.

## Interface
- `StallBus`: 6. Width of the stall bus. Bit 0 = PC, 1 = IF, 2 = ID, 3 = EX, 4 = MEM, 5 = WB. `Stop` = 1, `NoStop` = 0.

Ports:
- `clk`  in  1  clock
- `rst`  in  1  synchronous, active-high reset
- `flush`  in  1  exception/redirect flush
- `id_rs_raddr`, `id_rt_raddr`  in  5 each  ID source register addresses
- `id_rs_used`, `id_rt_used`  in  1 each  ID instruction reads rs / rt
- `ex_is_load`  in  1  EX holds a load
- `ex_wreg`  in  1  EX writes the register file
- `ex_waddr`  in  5  EX destination register
- `ex_div_op`  in  1  EX holds DIV/DIVU
- `div_ready`  in  1  divider result valid (1-cycle pulse)
- `div_result`  in  64  {hi, lo} from the divider
- `stallreq_mem`  in  1  data memory not ready
- `stall`  out  6  stall bus (combinational)
- `div_start`  out  1  registered one-cycle start pulse to the divider
- `div_abort`  out  1  registered one-cycle abort pulse to the divider
- `div_valid`  out  1  `div_hilo` is valid for EX this cycle
- `div_hilo`  out  64  captured divider result
- `stall_cycles`  out  32  count of cycles with `stall[0]` = 1; wraps

## Operation
- FSM states: `RUN`, `DIV_START`, `DIV_WAIT`, `DIV_DONE`.
- `RUN`:
  - `ex_div_op` = 1 → next state `DIV_START`; `stall` = 6'b001111 this cycle.
- `DIV_START`:
  - `div_start` = 1; `stall` = 6'b001111.
  - Next state `DIV_WAIT`.
- `DIV_WAIT`:
  - `stall` = 6'b001111.
  - `div_ready` = 1 → capture `div_result` into `div_hilo`, next state `DIV_DONE`.
- `DIV_DONE`:
  - `div_valid` = 1; the divider stall is released; `ex_div_op` is ignored.
  - Next state `RUN`.
- Load-use condition: `ex_is_load` & `ex_wreg` & (`ex_waddr` != 0) & ((`id_rs_used` & `ex_waddr` == `id_rs_raddr`) | (`id_rt_used` & `ex_waddr` == `id_rt_raddr`)).
  - Requests `stall` = 6'b000111. PC, IF and ID are held; a bubble enters EX.
- Memory wait: `stallreq_mem` = 1 requests `stall` = 6'b011111. A bubble enters WB.
- Combination: `stall` = bitwise OR of all active requests. Requests are prefix masks, so the OR equals the longest request.
- `flush` has highest priority:
  - `stall` = 0.
  - FSM → `RUN`.
  - If the state was `DIV_START` or `DIV_WAIT`, `div_abort` = 1 next cycle.
  - `div_valid` is suppressed; `div_ready` arriving during the flush cycle is discarded.
- `stall_cycles` increments by 1 when `stall[0]` = 1, mod 2^32.

## Timing
- Reset values:
  - `stall` = 0, `div_start` = 0, `div_abort` = 0, `div_valid` = 0.
  - `div_hilo` = 0, `stall_cycles` = 0, state `RUN`.
- Reset mid-division: returns to `RUN` with no abort pulse. The divider is reset by the same `rst`.
- `stall`:
  - Combinational from the current state and inputs.
  - Valid in the same cycle as the triggering input.
- `div_start`:
  - Asserted in the cycle after `ex_div_op` is detected in `RUN`.
  - Exactly one cycle per division.
- Minimum division stall: detect(1) + `DIV_START`(1) + `DIV_WAIT`(≥1) = 3 cycles with `stall[3]` = 1.
  - EX advances at the end of the `DIV_DONE` cycle.
- `div_ready` is ignored outside `DIV_WAIT`.
- Load-use stall lasts exactly one cycle. After the bubble, the load is in MEM and the condition clears.
- Load-use during a division: absorbed by the larger divider stall; no extra cycle.
- `stallreq_mem` during `DIV_DONE`: `stall` = 6'b011111, so EX is still held.
  - FSM still → `RUN`; `div_hilo` is retained.
  - Because `ex_div_op` stays 1, the division re-runs once the memory stall clears.
- `div_hilo` holds its value until the next capture.

## Test plan
- Reset, then idle 5 cycles → `stall` = 0, `stall_cycles` = 0, `div_start` never asserted.
- Load-use: `ex_is_load` = 1, `ex_wreg` = 1, `ex_waddr` = 8, `id_rs_used` = 1, `id_rs_raddr` = 8 → `stall` = 6'b000111 for 1 cycle, `stall_cycles` = 1. Repeat with `ex_waddr` = 0 → no stall.
- Division: `ex_div_op` = 1, `div_ready` 4 cycles after `div_start` with `div_result` = 64'h0000_0003_0000_0007 → `div_start` pulses once, `stall` = 6'b001111 for 6 cycles, then `div_valid` = 1 and `div_hilo` = 64'h0000_0003_0000_0007.
- Flush in `DIV_WAIT` → `stall` = 0 immediately, `div_abort` = 1 next cycle, state `RUN`. A later `div_ready` is ignored and `div_valid` stays 0.
- `stallreq_mem` = 1 together with load-use → `stall` = 6'b011111. Deassert `stallreq_mem` → 6'b000111 while the load-use condition persists.
- Force 2^32-1 counted cycles (preload via force) plus 1 stall → `stall_cycles` wraps to 0.

Source files
------------

// File: rtl/pipe_stall_ctrl_if.sv
// Handshake bundle between the pipeline datapath and the stall/sequencing controller.
// master = pipeline side (drives hazard/divider status), slave = controller.
interface pipe_stall_ctrl_if #(
  parameter int STALL_W = 6
);
  logic               flush;
  logic [4:0]         id_rs_raddr;
  logic [4:0]         id_rt_raddr;
  logic               id_rs_used;
  logic               id_rt_used;
  logic               ex_is_load;
  logic               ex_wreg;
  logic [4:0]         ex_waddr;
  logic               ex_div_op;
  logic               div_ready;
  logic [63:0]        div_result;
  logic               stallreq_mem;
  logic [STALL_W-1:0] stall;
  logic               div_start;
  logic               div_abort;
  logic               div_valid;
  logic [63:0]        div_hilo;
  logic [31:0]        stall_cycles;

  modport master (
    output flush, id_rs_raddr, id_rt_raddr, id_rs_used, id_rt_used,
           ex_is_load, ex_wreg, ex_waddr, ex_div_op, div_ready, div_result,
           stallreq_mem,
    input  stall, div_start, div_abort, div_valid, div_hilo, stall_cycles
  );

  modport slave (
    input  flush, id_rs_raddr, id_rt_raddr, id_rs_used, id_rt_used,
           ex_is_load, ex_wreg, ex_waddr, ex_div_op, div_ready, div_result,
           stallreq_mem,
    output stall, div_start, div_abort, div_valid, div_hilo, stall_cycles
  );
endinterface

// File: rtl/pipe_stall_ctrl.sv
// Central stall bus generator: load-use and memory-wait hazards plus the
// multi-cycle divider sequencer (start, wait, capture, release EX).

// One ID source operand compared against the EX destination.
module pipe_stall_src_cmp (
  input  logic       used,
  input  logic [4:0] raddr,
  input  logic [4:0] ex_waddr,
  output logic       hit
);
  assign hit = used && (raddr == ex_waddr);
endmodule

module pipe_stall_ctrl (
  input  logic             clk,
  input  logic             rst,
  pipe_stall_ctrl_if.slave bus
);
  localparam int NUM_SRC = 2;
  localparam int STALL_W = 6;

  // Stall requests are prefix masks (PC..stage), so OR-ing yields the longest.
  localparam logic [STALL_W-1:0] STALL_LU  = 6'b000111;
  localparam logic [STALL_W-1:0] STALL_DIV = 6'b001111;
  localparam logic [STALL_W-1:0] STALL_MEM = 6'b011111;

  typedef enum logic [1:0] {RUN, DIV_START, DIV_WAIT, DIV_DONE} state_t;

  state_t                       state, state_nxt;
  logic [NUM_SRC-1:0][4:0]      src_addr;
  logic [NUM_SRC-1:0]           src_used;
  logic [NUM_SRC-1:0]           src_hit;
  logic                         load_use;
  logic                         div_req;
  logic                         capture;
  logic                         valid_c;
  logic [STALL_W-1:0]           stall_c;
  logic                         div_start_q;
  logic                         div_abort_q;
  logic [63:0]                  div_hilo_q;
  logic [31:0]                  stall_cnt;

  // ---------------- load-use detection ----------------
  assign src_addr = {bus.id_rt_raddr, bus.id_rs_raddr};
  assign src_used = {bus.id_rt_used, bus.id_rs_used};

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    pipe_stall_src_cmp u_cmp (
      .used     (src_used[g]),
      .raddr    (src_addr[g]),
      .ex_waddr (bus.ex_waddr),
      .hit      (src_hit[g])
    );
  end

  assign load_use = bus.ex_is_load && bus.ex_wreg && (bus.ex_waddr != 5'd0) && (|src_hit);

  // ---------------- divider sequencer ----------------
  always_ff @(posedge clk) begin
    if (rst) state <= RUN;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    div_req   = 1'b0;
    capture   = 1'b0;
    valid_c   = 1'b0;
    case (state)
      RUN: begin
        if (bus.ex_div_op) begin
          div_req   = 1'b1;
          state_nxt = DIV_START;
        end
      end
      DIV_START: begin
        div_req   = 1'b1;
        state_nxt = DIV_WAIT;
      end
      DIV_WAIT: begin
        div_req = 1'b1;
        if (bus.div_ready) begin
          capture   = 1'b1;
          state_nxt = DIV_DONE;
        end
      end
      DIV_DONE: begin
        // EX advances at the end of this cycle unless memory still holds it.
        valid_c   = 1'b1;
        state_nxt = RUN;
      end
      default: state_nxt = RUN;
    endcase
    // Flush wins: drop any in-flight result and return to RUN.
    if (bus.flush) begin
      state_nxt = RUN;
      capture   = 1'b0;
      valid_c   = 1'b0;
    end
  end

  always_comb begin
    stall_c = '0;
    if (!bus.flush) begin
      if (load_use)         stall_c = stall_c | STALL_LU;
      if (div_req)          stall_c = stall_c | STALL_DIV;
      if (bus.stallreq_mem) stall_c = stall_c | STALL_MEM;
    end
  end

  // Reset intentionally produces no abort: the divider shares rst.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_start_q <= 1'b0;
      div_abort_q <= 1'b0;
      div_hilo_q  <= '0;
      stall_cnt   <= '0;
    end else begin
      div_start_q <= (state == RUN) && bus.ex_div_op && !bus.flush;
      div_abort_q <= bus.flush && ((state == DIV_START) || (state == DIV_WAIT));
      if (capture)    div_hilo_q <= bus.div_result;
      if (stall_c[0]) stall_cnt  <= stall_cnt + 32'd1;
    end
  end

  assign bus.stall        = stall_c;
  assign bus.div_start    = div_start_q;
  assign bus.div_abort    = div_abort_q;
  assign bus.div_valid    = valid_c;
  assign bus.div_hilo     = div_hilo_q;
  assign bus.stall_cycles = stall_cnt;
endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed bench for pipe_stall_ctrl: hazard stalls, divider sequencing,
// flush abort, memory-wait combining and stall counter wrap.
module tb_pipe_stall_ctrl;
  logic clk = 1'b0;
  logic rst;
  int   vec  = 0;
  int   errs = 0;
  logic [31:0] exp_cnt = 0;
  localparam logic [63:0] RES_A = 64'h0000_0003_0000_0007;
  localparam logic [63:0] RES_B = 64'hDEAD_BEEF_1234_5678;

  always #5 clk = ~clk;

  pipe_stall_ctrl_if bus ();

  pipe_stall_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.flush = 0; bus.id_rs_raddr = 0; bus.id_rt_raddr = 0;
    bus.id_rs_used = 0; bus.id_rt_used = 0; bus.ex_is_load = 0;
    bus.ex_wreg = 0; bus.ex_waddr = 0; bus.ex_div_op = 0;
    bus.div_ready = 0; bus.div_result = 0; bus.stallreq_mem = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1;
    tick(); tick();
    rst = 0;
    #1;
    vec++; if (bus.div_hilo !== 64'd0) begin errs++; $display("FAIL rst_hilo: got %h want 0", bus.div_hilo); end
    vec++; if (bus.div_abort !== 1'b0 || bus.div_valid !== 1'b0) begin errs++; $display("FAIL rst_div_flags: abort %b valid %b want 0 0", bus.div_abort, bus.div_valid); end
    for (int i = 0; i < 5; i++) begin
      tick();
      vec++; if (bus.stall !== 6'b0 || bus.div_start !== 1'b0 || bus.stall_cycles !== 32'd0) begin
        errs++; $display("FAIL idle_%0d: stall %b start %b cnt %0d want 0 0 0", i, bus.stall, bus.div_start, bus.stall_cycles);
      end
    end
  endtask

  task automatic test_load_use();
    // rs match
    bus.ex_is_load = 1; bus.ex_wreg = 1; bus.ex_waddr = 8; bus.id_rs_used = 1; bus.id_rs_raddr = 8;
    #1;
    vec++; if (bus.stall !== 6'b000111) begin errs++; $display("FAIL lu_rs: got %b want 000111", bus.stall); end
    tick(); exp_cnt += 1;
    idle_inputs(); #1;
    vec++; if (bus.stall !== 6'b0 || bus.stall_cycles !== exp_cnt) begin errs++; $display("FAIL lu_clear: stall %b cnt %0d want 0 %0d", bus.stall, bus.stall_cycles, exp_cnt); end
    // ex_waddr = 0 never hazards
    bus.ex_is_load = 1; bus.ex_wreg = 1; bus.ex_waddr = 0; bus.id_rs_used = 1; bus.id_rs_raddr = 0;
    #1;
    vec++; if (bus.stall !== 6'b0) begin errs++; $display("FAIL lu_r0: got %b want 0", bus.stall); end
    tick();
    vec++; if (bus.stall_cycles !== exp_cnt) begin errs++; $display("FAIL lu_r0_cnt: got %0d want %0d", bus.stall_cycles, exp_cnt); end
    // rt match, rs unused
    idle_inputs();
    bus.ex_is_load = 1; bus.ex_wreg = 1; bus.ex_waddr = 17; bus.id_rt_used = 1; bus.id_rt_raddr = 17; bus.id_rs_raddr = 17;
    #1;
    vec++; if (bus.stall !== 6'b000111) begin errs++; $display("FAIL lu_rt: got %b want 000111", bus.stall); end
    // address match but operand not read
    bus.id_rt_used = 0; #1;
    vec++; if (bus.stall !== 6'b0) begin errs++; $display("FAIL lu_unused: got %b want 0", bus.stall); end
    // not a load
    bus.id_rt_used = 1; bus.ex_is_load = 0; #1;
    vec++; if (bus.stall !== 6'b0) begin errs++; $display("FAIL lu_noload: got %b want 0", bus.stall); end
    bus.ex_is_load = 1; #1;
    tick(); exp_cnt += 1;
    idle_inputs(); #1;
    vec++; if (bus.stall_cycles !== exp_cnt) begin errs++; $display("FAIL lu_rt_cnt: got %0d want %0d", bus.stall_cycles, exp_cnt); end
  endtask

  task automatic test_div();
    // div_ready in RUN is ignored
    bus.div_ready = 1; bus.div_result = RES_B; tick();
    bus.div_ready = 0;
    bus.ex_div_op = 1; #1;
    vec++; if (bus.stall !== 6'b001111 || bus.div_start !== 1'b0) begin errs++; $display("FAIL div_detect: stall %b start %b want 001111 0", bus.stall, bus.div_start); end
    vec++; if (bus.div_hilo !== 64'd0) begin errs++; $display("FAIL div_ready_ignored: got %h want 0", bus.div_hilo); end
    tick();
    vec++; if (bus.stall !== 6'b001111 || bus.div_start !== 1'b1) begin errs++; $display("FAIL div_start: stall %b start %b want 001111 1", bus.stall, bus.div_start); end
    for (int i = 0; i < 3; i++) begin
      tick();
      vec++; if (bus.stall !== 6'b001111 || bus.div_start !== 1'b0 || bus.div_valid !== 1'b0) begin
        errs++; $display("FAIL div_wait_%0d: stall %b start %b valid %b want 001111 0 0", i, bus.stall, bus.div_start, bus.div_valid);
      end
    end
    tick();
    bus.div_ready = 1; bus.div_result = RES_A; #1;
    vec++; if (bus.stall !== 6'b001111) begin errs++; $display("FAIL div_ready_cyc: got %b want 001111", bus.stall); end
    tick(); exp_cnt += 6;
    bus.div_ready = 0; #1;
    vec++; if (bus.div_valid !== 1'b1 || bus.div_hilo !== RES_A || bus.stall !== 6'b0) begin
      errs++; $display("FAIL div_done: valid %b hilo %h stall %b want 1 %h 0", bus.div_valid, bus.div_hilo, bus.stall, RES_A);
    end
    vec++; if (bus.stall_cycles !== exp_cnt) begin errs++; $display("FAIL div_cnt: got %0d want %0d", bus.stall_cycles, exp_cnt); end
    tick();
    bus.ex_div_op = 0; #1;
    vec++; if (bus.div_valid !== 1'b0 || bus.stall !== 6'b0 || bus.div_start !== 1'b0) begin
      errs++; $display("FAIL div_release: valid %b stall %b start %b want 0 0 0", bus.div_valid, bus.stall, bus.div_start);
    end
  endtask

  task automatic test_flush_div();
    bus.ex_div_op = 1; tick();
    tick();
    bus.flush = 1; #1;
    vec++; if (bus.stall !== 6'b0 || bus.div_abort !== 1'b0) begin errs++; $display("FAIL flush_now: stall %b abort %b want 0 0", bus.stall, bus.div_abort); end
    tick(); exp_cnt += 2;
    bus.flush = 0; bus.ex_div_op = 0; #1;
    vec++; if (bus.div_abort !== 1'b1 || bus.stall !== 6'b0 || bus.div_valid !== 1'b0) begin
      errs++; $display("FAIL flush_abort: abort %b stall %b valid %b want 1 0 0", bus.div_abort, bus.stall, bus.div_valid);
    end
    tick();
    bus.div_ready = 1; bus.div_result = RES_B; #1;
    vec++; if (bus.div_abort !== 1'b0 || bus.div_valid !== 1'b0) begin errs++; $display("FAIL flush_abort_once: abort %b valid %b want 0 0", bus.div_abort, bus.div_valid); end
    tick();
    bus.div_ready = 0; #1;
    vec++; if (bus.div_valid !== 1'b0 || bus.div_hilo !== RES_A || bus.stall_cycles !== exp_cnt) begin
      errs++; $display("FAIL flush_late_ready: valid %b hilo %h cnt %0d want 0 %h %0d", bus.div_valid, bus.div_hilo, bus.stall_cycles, RES_A, exp_cnt);
    end
  endtask

  task automatic test_mem_combine();
    bus.ex_is_load = 1; bus.ex_wreg = 1; bus.ex_waddr = 5; bus.id_rs_used = 1; bus.id_rs_raddr = 5;
    bus.stallreq_mem = 1; #1;
    vec++; if (bus.stall !== 6'b011111) begin errs++; $display("FAIL mem_lu: got %b want 011111", bus.stall); end
    tick();
    bus.stallreq_mem = 0; #1;
    vec++; if (bus.stall !== 6'b000111) begin errs++; $display("FAIL mem_drop: got %b want 000111", bus.stall); end
    tick(); exp_cnt += 2;
    idle_inputs(); #1;
    vec++; if (bus.stall_cycles !== exp_cnt) begin errs++; $display("FAIL mem_cnt: got %0d want %0d", bus.stall_cycles, exp_cnt); end
  endtask

  task automatic test_mem_div_done();
    // detect, DIV_START, DIV_WAIT with immediate ready
    bus.ex_div_op = 1; tick(); tick();
    bus.div_ready = 1; bus.div_result = RES_B; tick();
    bus.div_ready = 0; bus.stallreq_mem = 1; #1;
    vec++; if (bus.stall !== 6'b011111 || bus.div_valid !== 1'b1) begin errs++; $display("FAIL done_mem: stall %b valid %b want 011111 1", bus.stall, bus.div_valid); end
    tick();
    bus.stallreq_mem = 0; #1;
    vec++; if (bus.stall !== 6'b001111 || bus.div_hilo !== RES_B || bus.div_start !== 1'b0) begin
      errs++; $display("FAIL done_rerun: stall %b hilo %h start %b want 001111 %h 0", bus.stall, bus.div_hilo, bus.div_start, RES_B);
    end
    tick(); exp_cnt += 5;
    vec++; if (bus.div_start !== 1'b1) begin errs++; $display("FAIL done_restart: got %b want 1", bus.div_start); end
    bus.flush = 1; tick();
    bus.flush = 0; bus.ex_div_op = 0; #1;
    vec++; if (bus.div_abort !== 1'b1 || bus.stall_cycles !== exp_cnt) begin
      errs++; $display("FAIL restart_abort: abort %b cnt %0d want 1 %0d", bus.div_abort, bus.stall_cycles, exp_cnt);
    end
    tick();
  endtask

  task automatic test_wrap();
    force dut.stall_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.stall_cnt;
    #1;
    vec++; if (bus.stall_cycles !== 32'hFFFF_FFFF) begin errs++; $display("FAIL wrap_preload: got %h want ffffffff", bus.stall_cycles); end
    bus.stallreq_mem = 1; tick();
    bus.stallreq_mem = 0; #1;
    vec++; if (bus.stall_cycles !== 32'd0) begin errs++; $display("FAIL wrap: got %h want 0", bus.stall_cycles); end
    tick();
    vec++; if (bus.stall_cycles !== 32'd0) begin errs++; $display("FAIL wrap_hold: got %h want 0", bus.stall_cycles); end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_div();
    test_flush_div();
    test_mem_combine();
    test_mem_div_done();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
